tile_scheduler: RTL and testbench

//  Sequences one layer's tile loop from layer_decoder outputs. Each tile is issued as a

---
 rtl/tile_sched_pkg.sv | 55 +++++
 rtl/tile_addr_gen.sv | 114 +++++++++++
 rtl/tile_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_tile_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_sched_pkg.sv
// rtl/tile_sched_pkg.sv - shared widths, layer-type codes, FSM states and record types for the tile scheduler
//
// Purpose: single home for the datapath widths and types used by tile_scheduler and
// tile_addr_gen. Widths are tuned here rather than per instance so the packed
// structs below always agree with the port widths.
//   ADDR_W  DRAM address width
//   DIM_W   channel-count width (in_D, out_K)
//   TILE_W  tile-size width (tile_D, tile_K)
//   HW_W    feature-map plane-size width (R*C)
//   DW_KSZ  depthwise weight bytes per channel (3x3)
package tile_sched_pkg;

  localparam int ADDR_W = 32;
  localparam int DIM_W  = 11;
  localparam int TILE_W = 7;
  localparam int HW_W   = 14;
  localparam int DW_KSZ = 9;

  localparam logic [1:0] LT_POINTWISE = 2'd0;
  localparam logic [1:0] LT_DEPTHWISE = 2'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    ADV   = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [DIM_W-1:0]  d_idx;
    logic [DIM_W-1:0]  k_idx;
    logic [TILE_W-1:0] d_size;
    logic [TILE_W-1:0] k_size;
    logic              psum_first;
    logic              psum_last;
  } tile_desc_t;

  typedef struct packed {
    logic              is_dw;
    logic [DIM_W-1:0]  in_d;
    logic [DIM_W-1:0]  out_k;
    logic [TILE_W-1:0] tile_d;
    logic [TILE_W-1:0] tile_k;
    logic [TILE_W-1:0] tile_d_f;
    logic [TILE_W-1:0] tile_k_f;
    logic [HW_W-1:0]   in_hw;
    logic [HW_W-1:0]   out_hw;
    logic [ADDR_W-1:0] base_ifmap;
    logic [ADDR_W-1:0] base_weight;
    logic [ADDR_W-1:0] base_ofmap;
  } layer_cfg_t;

endpackage

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - stride registers and incremental DRAM address accumulators
//
// Purpose: computes the per-tile ifmap/weight/ofmap addresses. All multiplies happen
// once in setup_i; each advance is a plain add (modulo 2^ADDR_W).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   setup_i           load strides and reset accumulators to the bases
//   adv_i             step to the next tile
//   is_dw_i           depthwise layer (single D loop)
//   d_wrap_i          pointwise: current tile was the last D tile (step K instead of D)
//   tile_d_i/tile_k_i nominal tile sizes
//   in_d_i            input channel count (weight row pitch for pointwise)
//   in_hw_i/out_hw_i  ifmap / ofmap plane sizes
//   base_*_i          layer base addresses
//   *_addr_o          current tile addresses
module tile_addr_gen
  import tile_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setup_i,
  input  logic              adv_i,
  input  logic              is_dw_i,
  input  logic              d_wrap_i,
  input  logic [TILE_W-1:0] tile_d_i,
  input  logic [TILE_W-1:0] tile_k_i,
  input  logic [DIM_W-1:0]  in_d_i,
  input  logic [HW_W-1:0]   in_hw_i,
  input  logic [HW_W-1:0]   out_hw_i,
  input  logic [ADDR_W-1:0] base_ifmap_i,
  input  logic [ADDR_W-1:0] base_weight_i,
  input  logic [ADDR_W-1:0] base_ofmap_i,
  output logic [ADDR_W-1:0] ifmap_addr_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic [ADDR_W-1:0] ofmap_addr_o
);

  logic [ADDR_W-1:0] stride_if_q,  stride_if_d;
  logic [ADDR_W-1:0] stride_wk_q,  stride_wk_d;
  logic [ADDR_W-1:0] stride_ofk_q, stride_ofk_d;
  logic [ADDR_W-1:0] stride_ofd_q, stride_ofd_d;
  logic [ADDR_W-1:0] stride_dw_q,  stride_dw_d;
  logic [ADDR_W-1:0] ifmap_q,  ifmap_d;
  logic [ADDR_W-1:0] weight_q, weight_d;
  logic [ADDR_W-1:0] ofmap_q,  ofmap_d;
  // Weight address of the first D tile of the current K group.
  logic [ADDR_W-1:0] kbase_q,  kbase_d;

  always_comb begin
    stride_if_d  = stride_if_q;
    stride_wk_d  = stride_wk_q;
    stride_ofk_d = stride_ofk_q;
    stride_ofd_d = stride_ofd_q;
    stride_dw_d  = stride_dw_q;
    ifmap_d      = ifmap_q;
    weight_d     = weight_q;
    ofmap_d      = ofmap_q;
    kbase_d      = kbase_q;
    if (setup_i) begin
      stride_if_d  = ADDR_W'(tile_d_i) * ADDR_W'(in_hw_i);
      stride_wk_d  = ADDR_W'(tile_k_i) * ADDR_W'(in_d_i);
      stride_ofk_d = ADDR_W'(tile_k_i) * ADDR_W'(out_hw_i);
      stride_ofd_d = ADDR_W'(tile_d_i) * ADDR_W'(out_hw_i);
      stride_dw_d  = ADDR_W'(tile_d_i) * ADDR_W'(DW_KSZ);
      ifmap_d      = base_ifmap_i;
      weight_d     = base_weight_i;
      kbase_d      = base_weight_i;
      ofmap_d      = base_ofmap_i;
    end else if (adv_i) begin
      if (is_dw_i) begin
        ifmap_d  = ifmap_q + stride_if_q;
        weight_d = weight_q + stride_dw_q;
        ofmap_d  = ofmap_q + stride_ofd_q;
      end else if (!d_wrap_i) begin
        ifmap_d  = ifmap_q + stride_if_q;
        weight_d = weight_q + ADDR_W'(tile_d_i);
      end else begin
        ifmap_d  = base_ifmap_i;
        kbase_d  = kbase_q + stride_wk_q;
        weight_d = kbase_q + stride_wk_q;
        ofmap_d  = ofmap_q + stride_ofk_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_if_q  <= '0;
      stride_wk_q  <= '0;
      stride_ofk_q <= '0;
      stride_ofd_q <= '0;
      stride_dw_q  <= '0;
      ifmap_q      <= '0;
      weight_q     <= '0;
      ofmap_q      <= '0;
      kbase_q      <= '0;
    end else begin
      stride_if_q  <= stride_if_d;
      stride_wk_q  <= stride_wk_d;
      stride_ofk_q <= stride_ofk_d;
      stride_ofd_q <= stride_ofd_d;
      stride_dw_q  <= stride_dw_d;
      ifmap_q      <= ifmap_d;
      weight_q     <= weight_d;
      ofmap_q      <= ofmap_d;
      kbase_q      <= kbase_d;
    end
  end

  assign ifmap_addr_o  = ifmap_q;
  assign weight_addr_o = weight_q;
  assign ofmap_addr_o  = ofmap_q;

endmodule

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - sequences one layer's tile loop into a valid/ready descriptor stream
//
// Purpose: on start_i, walks the tile loop (pointwise: K outer, D inner; depthwise: D only),
// issuing one registered descriptor per tile and waiting for tile_done_i before advancing.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_i                     begin a layer (config inputs valid this cycle)
//   layer_type_i ... base_*_i   layer configuration
//   busy_o                      layer in progress
//   tile_valid_o / tile_ready_i descriptor handshake
//   tile_*_o, *_addr_o, psum_*  descriptor fields
//   tile_done_i                 issued tile fully processed
//   layer_done_o                one-cycle pulse after the last tile
module tile_scheduler
  import tile_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        layer_type_i,
  input  logic [DIM_W-1:0]  in_D_i,
  input  logic [DIM_W-1:0]  out_K_i,
  input  logic [TILE_W-1:0] tile_D_i,
  input  logic [TILE_W-1:0] tile_K_i,
  input  logic [TILE_W-1:0] tile_D_f_i,
  input  logic [TILE_W-1:0] tile_K_f_i,
  input  logic [HW_W-1:0]   in_HW_i,
  input  logic [HW_W-1:0]   out_HW_i,
  input  logic [ADDR_W-1:0] base_ifmap_i,
  input  logic [ADDR_W-1:0] base_weight_i,
  input  logic [ADDR_W-1:0] base_ofmap_i,
  output logic              busy_o,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [DIM_W-1:0]  tile_d_idx_o,
  output logic [DIM_W-1:0]  tile_k_idx_o,
  output logic [TILE_W-1:0] tile_d_size_o,
  output logic [TILE_W-1:0] tile_k_size_o,
  output logic [ADDR_W-1:0] ifmap_addr_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic [ADDR_W-1:0] ofmap_addr_o,
  output logic              psum_first_o,
  output logic              psum_last_o,
  input  logic              tile_done_i,
  output logic              layer_done_o
);

  state_t     state_q, state_d;
  layer_cfg_t cfg_q, cfg_d;
  tile_desc_t desc_q, desc_d;
  // d_last of the current tile (drives the D/K step in ADV), and whether it is the final tile.
  logic d_last_q, d_last_d;
  logic last_tile_q, last_tile_d;

  logic              load_desc, addr_setup, addr_adv, cfg_empty;
  logic [DIM_W-1:0]  nxt_d, nxt_k;
  logic [DIM_W:0]    d_end, k_end;
  logic              nxt_d_last, nxt_k_last;

  assign cfg_empty = (cfg_q.in_d == '0) || (cfg_q.tile_d == '0) ||
                     (!cfg_q.is_dw && ((cfg_q.out_k == '0) || (cfg_q.tile_k == '0)));

  // Indices of the tile about to be loaded: zero in SETUP, stepped in ADV.
  always_comb begin
    nxt_d = '0;
    nxt_k = '0;
    if (state_q == ADV) begin
      if (cfg_q.is_dw) begin
        nxt_d = desc_q.d_idx + DIM_W'(cfg_q.tile_d);
        nxt_k = nxt_d;
      end else if (!d_last_q) begin
        nxt_d = desc_q.d_idx + DIM_W'(cfg_q.tile_d);
        nxt_k = desc_q.k_idx;
      end else begin
        nxt_d = '0;
        nxt_k = desc_q.k_idx + DIM_W'(cfg_q.tile_k);
      end
    end
    // One extra bit so idx+tile cannot wrap before the compare.
    d_end      = {1'b0, nxt_d} + (DIM_W+1)'(cfg_q.tile_d);
    k_end      = {1'b0, nxt_k} + (DIM_W+1)'(cfg_q.tile_k);
    nxt_d_last = (d_end >= {1'b0, cfg_q.in_d});
    nxt_k_last = (k_end >= {1'b0, cfg_q.out_k});
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    desc_d      = desc_q;
    d_last_d    = d_last_q;
    last_tile_d = last_tile_q;
    load_desc   = 1'b0;
    addr_setup  = 1'b0;
    addr_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cfg_d.is_dw       = (layer_type_i == LT_DEPTHWISE);
          cfg_d.in_d        = in_D_i;
          cfg_d.out_k       = out_K_i;
          cfg_d.tile_d      = tile_D_i;
          cfg_d.tile_k      = tile_K_i;
          cfg_d.tile_d_f    = tile_D_f_i;
          cfg_d.tile_k_f    = tile_K_f_i;
          cfg_d.in_hw       = in_HW_i;
          cfg_d.out_hw      = out_HW_i;
          cfg_d.base_ifmap  = base_ifmap_i;
          cfg_d.base_weight = base_weight_i;
          cfg_d.base_ofmap  = base_ofmap_i;
          state_d           = SETUP;
        end
      end
      SETUP: begin
        load_desc  = 1'b1;
        addr_setup = 1'b1;
        state_d    = cfg_empty ? DONE : ISSUE;
      end
      ISSUE: if (tile_ready_i) state_d = WAIT;
      WAIT:  if (tile_done_i) state_d = last_tile_q ? DONE : ADV;
      ADV: begin
        load_desc = 1'b1;
        addr_adv  = 1'b1;
        state_d   = ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_desc) begin
      desc_d.d_idx      = nxt_d;
      desc_d.k_idx      = nxt_k;
      desc_d.d_size     = nxt_d_last ? cfg_q.tile_d_f : cfg_q.tile_d;
      desc_d.k_size     = cfg_q.is_dw ? desc_d.d_size
                                      : (nxt_k_last ? cfg_q.tile_k_f : cfg_q.tile_k);
      desc_d.psum_first = cfg_q.is_dw | (nxt_d == '0);
      desc_d.psum_last  = cfg_q.is_dw | nxt_d_last;
      d_last_d          = nxt_d_last;
      last_tile_d       = nxt_d_last & (cfg_q.is_dw | nxt_k_last);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      desc_q      <= '0;
      d_last_q    <= 1'b0;
      last_tile_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      desc_q      <= desc_d;
      d_last_q    <= d_last_d;
      last_tile_q <= last_tile_d;
    end
  end

  tile_addr_gen u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .setup_i       (addr_setup),
    .adv_i         (addr_adv),
    .is_dw_i       (cfg_q.is_dw),
    .d_wrap_i      (d_last_q),
    .tile_d_i      (cfg_q.tile_d),
    .tile_k_i      (cfg_q.tile_k),
    .in_d_i        (cfg_q.in_d),
    .in_hw_i       (cfg_q.in_hw),
    .out_hw_i      (cfg_q.out_hw),
    .base_ifmap_i  (cfg_q.base_ifmap),
    .base_weight_i (cfg_q.base_weight),
    .base_ofmap_i  (cfg_q.base_ofmap),
    .ifmap_addr_o  (ifmap_addr_o),
    .weight_addr_o (weight_addr_o),
    .ofmap_addr_o  (ofmap_addr_o)
  );

  assign busy_o        = (state_q != IDLE);
  assign tile_valid_o  = (state_q == ISSUE);
  assign layer_done_o  = (state_q == DONE);
  assign tile_d_idx_o  = desc_q.d_idx;
  assign tile_k_idx_o  = desc_q.k_idx;
  assign tile_d_size_o = desc_q.d_size;
  assign tile_k_size_o = desc_q.k_size;
  assign psum_first_o  = desc_q.psum_first;
  assign psum_last_o   = desc_q.psum_last;

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - scoreboard bench for tile_scheduler
module tb_tile_scheduler;
  import tile_sched_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic [1:0]        layer_type_i;
  logic [DIM_W-1:0]  in_D_i, out_K_i;
  logic [TILE_W-1:0] tile_D_i, tile_K_i, tile_D_f_i, tile_K_f_i;
  logic [HW_W-1:0]   in_HW_i, out_HW_i;
  logic [ADDR_W-1:0] base_ifmap_i, base_weight_i, base_ofmap_i;
  logic              busy_o, tile_valid_o, tile_ready_i;
  logic [DIM_W-1:0]  tile_d_idx_o, tile_k_idx_o;
  logic [TILE_W-1:0] tile_d_size_o, tile_k_size_o;
  logic [ADDR_W-1:0] ifmap_addr_o, weight_addr_o, ofmap_addr_o;
  logic              psum_first_o, psum_last_o, tile_done_i, layer_done_o;

  tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .layer_type_i(layer_type_i),
    .in_D_i(in_D_i), .out_K_i(out_K_i), .tile_D_i(tile_D_i), .tile_K_i(tile_K_i),
    .tile_D_f_i(tile_D_f_i), .tile_K_f_i(tile_K_f_i), .in_HW_i(in_HW_i), .out_HW_i(out_HW_i),
    .base_ifmap_i(base_ifmap_i), .base_weight_i(base_weight_i), .base_ofmap_i(base_ofmap_i),
    .busy_o(busy_o), .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .tile_d_idx_o(tile_d_idx_o), .tile_k_idx_o(tile_k_idx_o),
    .tile_d_size_o(tile_d_size_o), .tile_k_size_o(tile_k_size_o),
    .ifmap_addr_o(ifmap_addr_o), .weight_addr_o(weight_addr_o), .ofmap_addr_o(ofmap_addr_o),
    .psum_first_o(psum_first_o), .psum_last_o(psum_last_o),
    .tile_done_i(tile_done_i), .layer_done_o(layer_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d, k, ds, ks, ia, wa, oa;
    logic        first, last;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [159:0] desc_vec();
    return {tile_d_idx_o, tile_k_idx_o, tile_d_size_o, tile_k_size_o,
            ifmap_addr_o, weight_addr_o, ofmap_addr_o, psum_first_o, psum_last_o};
  endfunction

  task automatic set_cfg(input logic [1:0] lt, input int ind, input int outk, input int td,
                         input int tk, input int tdf, input int tkf, input int inhw,
                         input int outhw, input logic [31:0] bi, input logic [31:0] bw,
                         input logic [31:0] bo);
    layer_type_i  = lt;
    in_D_i        = DIM_W'(ind);
    out_K_i       = DIM_W'(outk);
    tile_D_i      = TILE_W'(td);
    tile_K_i      = TILE_W'(tk);
    tile_D_f_i    = TILE_W'(tdf);
    tile_K_f_i    = TILE_W'(tkf);
    in_HW_i       = HW_W'(inhw);
    out_HW_i      = HW_W'(outhw);
    base_ifmap_i  = bi;
    base_weight_i = bw;
    base_ofmap_i  = bo;
  endtask

  // Reference model: direct (multiplying) address formulas over the full loop nest.
  task automatic build_expected();
    int ind, outk, td, tk;
    bit dw;
    exp_t e;
    ind  = int'(in_D_i);
    outk = int'(out_K_i);
    td   = int'(tile_D_i);
    tk   = int'(tile_K_i);
    dw   = (layer_type_i == LT_DEPTHWISE);
    exp_q.delete();
    if (ind == 0 || td == 0 || (!dw && (outk == 0 || tk == 0))) return;
    if (dw) begin
      for (int d = 0; d < ind; d += td) begin
        bit dl = (d + td >= ind);
        e.d = d; e.k = d;
        e.ds = dl ? 32'(tile_D_f_i) : 32'(td);
        e.ks = e.ds;
        e.ia = base_ifmap_i + 32'(d) * 32'(in_HW_i);
        e.wa = base_weight_i + 32'(d) * 32'(DW_KSZ);
        e.oa = base_ofmap_i + 32'(d) * 32'(out_HW_i);
        e.first = 1'b1; e.last = 1'b1;
        exp_q.push_back(e);
      end
    end else begin
      for (int k = 0; k < outk; k += tk) begin
        for (int d = 0; d < ind; d += td) begin
          bit dl = (d + td >= ind);
          bit kl = (k + tk >= outk);
          e.d = d; e.k = k;
          e.ds = dl ? 32'(tile_D_f_i) : 32'(td);
          e.ks = kl ? 32'(tile_K_f_i) : 32'(tk);
          e.ia = base_ifmap_i + 32'(d) * 32'(in_HW_i);
          e.wa = base_weight_i + 32'(k) * 32'(ind) + 32'(d);
          e.oa = base_ofmap_i + 32'(k) * 32'(out_HW_i);
          e.first = (d == 0); e.last = dl;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_done();
    repeat (2) @(posedge clk);
    #1 tile_done_i = 1'b1;
    @(posedge clk);
    #1 tile_done_i = 1'b0;
  endtask

  task automatic run_layer(input int stall);
    int   cyc, tiles, ndone, nvalid;
    logic [159:0] snap;
    exp_t e;
    tiles = 0;
    build_expected();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    while (exp_q.size() > 0) begin
      cyc = 0;
      @(negedge clk);
      while (!tile_valid_o && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      if (!tile_valid_o) begin
        check("valid_timeout", 0, 1);
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      check("d_idx",  tile_d_idx_o,  e.d);
      check("k_idx",  tile_k_idx_o,  e.k);
      check("d_size", tile_d_size_o, e.ds);
      check("k_size", tile_k_size_o, e.ks);
      check("ifmap",  ifmap_addr_o,  e.ia);
      check("weight", weight_addr_o, e.wa);
      check("ofmap",  ofmap_addr_o,  e.oa);
      check("first",  psum_first_o,  e.first);
      check("last",   psum_last_o,   e.last);
      if (tiles == 0 && stall > 0) begin
        snap = desc_vec();
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          check("stall_valid", tile_valid_o, 1);
          check("stall_desc", desc_vec(), snap);
        end
      end
      tile_ready_i = 1'b1;
      @(posedge clk);
      #1 tile_ready_i = 1'b0;
      @(negedge clk);
      check("wait_no_valid", tile_valid_o, 0);
      pulse_done();
      tiles++;
    end
    ndone = 0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (layer_done_o) ndone++;
      if (tile_valid_o) nvalid++;
    end
    check("layer_done_cnt", ndone, 1);
    check("extra_valid", nvalid, 0);
    check("busy_end", busy_o, 0);
  endtask

  initial begin
    int cyc, nbusy, ndone, nvalid, nact;
    rst_n = 1'b0; start_i = 1'b0; tile_ready_i = 1'b0; tile_done_i = 1'b0;
    set_cfg(LT_POINTWISE, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid", tile_valid_o, 0);
    check("rst_done", layer_done_o, 0);
    check("rst_desc", desc_vec(), 0);
    rst_n = 1'b1;

    // Pointwise 2x2 tiles, first tile stalled 5 cycles with ready low.
    set_cfg(LT_POINTWISE, 64, 64, 32, 32, 32, 32, 1024, 1024,
            32'h1000_0000, 32'h2000_0000, 32'h4000_0000);
    run_layer(5);

    // Pointwise with a short last D tile.
    set_cfg(LT_POINTWISE, 40, 32, 32, 32, 8, 32, 256, 256,
            32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
    run_layer(0);

    // Depthwise, out_K ignored.
    set_cfg(LT_DEPTHWISE, 64, 0, 32, 0, 32, 0, 100, 49,
            32'h0000_5000, 32'h0000_0000, 32'h0000_9000);
    run_layer(0);

    // Reset during WAIT of tile 2, stale tile_done ignored, clean restart.
    set_cfg(LT_POINTWISE, 64, 64, 32, 32, 32, 32, 1024, 1024,
            32'h1000_0000, 32'h2000_0000, 32'h4000_0000);
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int t = 0; t < 2; t++) begin
      cyc = 0;
      @(negedge clk);
      while (!tile_valid_o && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("rst_seq_valid", tile_valid_o, 1);
      tile_ready_i = 1'b1;
      @(posedge clk);
      #1 tile_ready_i = 1'b0;
      if (t == 0) pulse_done();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", tile_valid_o, 0);
    check("midrst_done", layer_done_o, 0);
    check("midrst_desc", desc_vec(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1; tile_done_i = 1'b1;
    @(posedge clk);
    #1 tile_done_i = 1'b0;
    nact = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_o || tile_valid_o || layer_done_o) nact++;
    end
    check("postrst_idle", nact, 0);
    run_layer(0);

    // Empty layer; a second start while busy is ignored.
    set_cfg(LT_POINTWISE, 0, 64, 32, 32, 32, 32, 1024, 1024,
            32'h1000_0000, 32'h2000_0000, 32'h4000_0000);
    @(posedge clk); #1 start_i = 1'b1;
    nbusy = 0; ndone = 0; nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 start_i = (i == 0);
      @(negedge clk);
      if (busy_o) nbusy++;
      if (layer_done_o) ndone++;
      if (tile_valid_o) nvalid++;
    end
    check("empty_busy_cycles", nbusy, 2);
    check("empty_done_cnt", ndone, 1);
    check("empty_valid", nvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
